// File: rtl/riscv_pkg.sv
// Shared front-end definitions: fetch FSM encoding, reset vector and the
// instruction buffer entry layout.
package riscv_pkg;
  localparam int          XLEN         = 32;
  localparam int          ILEN         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    F_IDLE    = 2'd0,
    F_WAIT    = 2'd1,
    F_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] ins;
    logic [XLEN-1:0] pc;
  } ibuf_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: power-of-two circular FIFO with a same-cycle flush.
// Storage resets to zero so the head reads as zero after reset.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  // Extra pointer bit distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign head_data = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, in-order responses,
// small instruction buffer toward decode, redirect flushes everything.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] ins_pc
);
  localparam int          CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);

  fetch_state_e  state, state_nxt;
  logic [31:0]   fetch_pc, req_pc;
  logic          req_fire, rsp_keep, push, pop, full, empty;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  ibuf_entry_t   head, push_entry;

  // Occupancy counts the outstanding word even if it lands this cycle.
  assign occ = {1'b0, count} + {{CW{1'b0}}, state == F_WAIT};

  // In WAIT a new request may only go out alongside the returning response.
  assign imem_req_valid = !rst && !redirect_valid && (occ < DEPTH_C) &&
                          ((state == F_IDLE) || (state == F_WAIT && imem_rsp_valid));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep   = (state == F_WAIT) && imem_rsp_valid && !redirect_valid;
  assign push       = rsp_keep && (!full || pop);
  assign push_entry = '{ins: imem_rsp_data, pc: req_pc};

  assign ins_valid = !rst && !empty && !redirect_valid;
  assign pop       = ins_valid && ins_ready;
  assign ins       = head.ins;
  assign ins_pc    = head.pc;

  always_comb begin
    state_nxt = state;
    case (state)
      F_IDLE:    if (req_fire) state_nxt = F_WAIT;
      F_WAIT: begin
        if (imem_rsp_valid)      state_nxt = req_fire ? F_WAIT : F_IDLE;
        else if (redirect_valid) state_nxt = F_DISCARD;
      end
      F_DISCARD: if (imem_rsp_valid) state_nxt = F_IDLE;
      default:   state_nxt = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= F_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (req_fire)  fetch_pc <= fetch_pc + 32'd4;
      if (req_fire) req_pc <= fetch_pc;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH ($bits(ibuf_entry_t))
  ) u_ibuf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_data (push_entry),
    .head_data (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );
endmodule
